// File: rtl/video_gen_ctrl.sv
// video_gen_ctrl: run controller and AXI-stream frame monitor for the test-pattern source (watchdog under VGC_TIMEOUT_EN)
module video_gen_ctrl #(
    parameter int FRAME_W = 16,
    parameter int TIMEOUT = 1048576
) (
    input  logic               pclk,
    input  logic               prst,
    input  logic               start,
    input  logic               stop,
    input  logic [FRAME_W-1:0] frame_limit,
    input  logic [15:0]        hactive,
    input  logic [15:0]        vactive,
    input  logic               axis_tvalid,
    input  logic               axis_tready,
    input  logic               axis_tuser,
    input  logic               axis_tlast,
    output logic               gen_enable,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               line_len_err,
    output logic               line_cnt_err,
    output logic [15:0]        drop_cnt,
    output logic               err_timeout
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;
    state_t state;
    logic [FRAME_W-1:0] limit, frame_n;
    logic [15:0] pix_cnt, line_cnt, pix_base, line_base, line_inc, pix_n, line_n;
    logic stop_pend, hs, sof, eol, act, track, restart, len_bad, eof, done, wd_fire;
    assign hs = axis_tvalid & axis_tready;
    assign sof = hs & axis_tuser;
    assign eol = hs & axis_tlast;
    assign busy = state != IDLE;
    assign act = state == ARM || state == RUN;
    // A short frame restarts counting at its sof beat, which is pixel 1 of line 0
    always_comb begin
        track = state == RUN || (state == ARM && sof && !stop);
        restart = state == RUN && sof && line_cnt != 16'd0;
        pix_base = restart ? 16'd0 : pix_cnt;
        line_base = restart ? 16'd0 : line_cnt;
        line_inc = line_base + 16'd1;
        len_bad = eol && (pix_base + 16'd1 != hactive);
        eof = eol && line_inc == vactive;
        pix_n = !hs ? pix_base : eol ? 16'd0 : pix_base + 16'd1;
        line_n = !eol ? line_base : eof ? 16'd0 : line_inc;
        frame_n = eof && frame_cnt != '1 ? frame_cnt + 1'b1 : frame_cnt;
        done = eof && (stop_pend || stop || (limit != '0 && frame_n == limit));
    end
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state <= IDLE;
            gen_enable <= 1'b0;
            frame_cnt <= '0;
            limit <= '0;
            line_len_err <= 1'b0;
            line_cnt_err <= 1'b0;
            drop_cnt <= '0;
            stop_pend <= 1'b0;
            pix_cnt <= '0;
            line_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= ARM;
                    gen_enable <= 1'b1;
                    frame_cnt <= '0;
                    limit <= frame_limit;
                    line_len_err <= 1'b0;
                    line_cnt_err <= 1'b0;
                    drop_cnt <= '0;
                    stop_pend <= 1'b0;
                    pix_cnt <= '0;
                    line_cnt <= '0;
                end
                ARM: if (stop) begin
                    state <= IDLE;
                    gen_enable <= 1'b0;
                end else if (sof) state <= RUN;
                RUN: begin
                    if (stop) stop_pend <= 1'b1;
                    if (done) state <= DRAIN;
                end
                default: begin
                    state <= IDLE;
                    gen_enable <= 1'b0;
                end
            endcase
            if (track) begin
                pix_cnt <= pix_n;
                line_cnt <= line_n;
                frame_cnt <= frame_n;
                if (len_bad) line_len_err <= 1'b1;
                if (restart) line_cnt_err <= 1'b1;
            end
            if (act && axis_tvalid && !axis_tready && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (wd_fire) begin
                state <= IDLE;
                gen_enable <= 1'b0;
            end
        end
    end
`ifdef VGC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd;
    assign wd_fire = act && !hs && wd == WD_W'(TIMEOUT - 1);
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            wd <= '0;
            err_timeout <= 1'b0;
        end else begin
            wd <= act && !hs && !wd_fire ? wd + 1'b1 : '0;
            if (state == IDLE && start) err_timeout <= 1'b0;
            else if (wd_fire) err_timeout <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_video_gen_ctrl.sv
// tb_video_gen_ctrl: table-driven runs with a frame-count scoreboard plus hand-written corner sequences
module tb_video_gen_ctrl;
    logic pclk = 1'b0, prst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [15:0] frame_limit = '0, hactive = 16'd8, vactive = 16'd4;
    logic axis_tvalid = 1'b0, axis_tready = 1'b1, axis_tuser = 1'b0, axis_tlast = 1'b0;
    logic gen_enable, busy, line_len_err, line_cnt_err, err_timeout;
    logic [15:0] frame_cnt, drop_cnt;
    int checks = 0, errors = 0;
    int q[$];
    typedef struct {
        int limit; int nfr; int sl_fr; int sf_fr; int stall; int stop_fr;
        int exp_fr; int exp_len; int exp_cnt; int exp_drop;
    } vec_t;
    vec_t vecs[6];

    video_gen_ctrl dut (
        .pclk(pclk), .prst(prst), .start(start), .stop(stop), .frame_limit(frame_limit),
        .hactive(hactive), .vactive(vactive), .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
        .axis_tuser(axis_tuser), .axis_tlast(axis_tlast), .gen_enable(gen_enable), .busy(busy),
        .frame_cnt(frame_cnt), .line_len_err(line_len_err), .line_cnt_err(line_cnt_err),
        .drop_cnt(drop_cnt), .err_timeout(err_timeout)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic do_start(input int lim, input bit with_stop);
        start = 1'b1;
        stop = with_stop;
        frame_limit = 16'(lim);
        cyc();
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic beat(input bit u, input bit l);
        axis_tvalid = 1'b1;
        axis_tready = 1'b1;
        axis_tuser = u;
        axis_tlast = l;
        cyc();
        axis_tvalid = 1'b0;
        axis_tuser = 1'b0;
        axis_tlast = 1'b0;
    endtask

    task automatic send_line(input int len, input bit first, input int stop_at);
        for (int i = 0; i < len; i++) begin
            stop = (i == stop_at);
            beat(first && i == 0, i == len - 1);
            stop = 1'b0;
        end
    endtask

    task automatic send_frame();
        for (int ln = 0; ln < 4; ln++) send_line(8, ln == 0, -1);
    endtask

    task automatic drain_chk(input string tag);
        chk({tag, " drain gen_enable"}, gen_enable, 1);
        chk({tag, " drain busy"}, busy, 1);
        cyc();
        chk({tag, " end gen_enable"}, gen_enable, 0);
        chk({tag, " end busy"}, busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int exp_fr;
        int nl;
        string tag;
        tag = $sformatf("v%0d", idx);
        exp_fr = 0;
        do_start(v.limit, 1'b0);
        chk({tag, " start gen_enable"}, gen_enable, 1);
        chk({tag, " start frame_cnt"}, frame_cnt, 0);
        chk({tag, " start drop_cnt"}, drop_cnt, 0);
        chk({tag, " start errs"}, {line_len_err, line_cnt_err}, 0);
        if (v.stall > 0) begin
            axis_tvalid = 1'b1;
            axis_tready = 1'b0;
            repeat (v.stall) @(negedge pclk);
            axis_tvalid = 1'b0;
            axis_tready = 1'b1;
        end
        for (int f = 1; f <= v.nfr; f++) begin
            nl = (f == v.sf_fr) ? 3 : 4;
            for (int ln = 0; ln < nl; ln++)
                send_line((f == v.sl_fr && ln == 1) ? 7 : 8, ln == 0, (f == v.stop_fr && ln == 1) ? 3 : -1);
            if (nl == 4) begin
                exp_fr++;
                q.push_back(exp_fr);
                chk($sformatf("%s frame_cnt f%0d", tag, f), frame_cnt, q.pop_front());
            end
        end
        drain_chk(tag);
        chk({tag, " final frame_cnt"}, frame_cnt, v.exp_fr);
        chk({tag, " line_len_err"}, line_len_err, v.exp_len);
        chk({tag, " line_cnt_err"}, line_cnt_err, v.exp_cnt);
        chk({tag, " drop_cnt"}, drop_cnt, v.exp_drop);
        chk({tag, " err_timeout"}, err_timeout, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3, 3, 0, 0, 0, 0, 3, 0, 0, 0};
        vecs[1] = '{0, 5, 0, 0, 0, 5, 5, 0, 0, 0};
        vecs[2] = '{2, 2, 1, 0, 0, 0, 2, 1, 0, 0};
        vecs[3] = '{2, 3, 0, 1, 0, 0, 2, 0, 1, 0};
        vecs[4] = '{1, 1, 0, 0, 10, 0, 1, 0, 0, 10};
        vecs[5] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        repeat (2) @(negedge pclk);
        chk("reset outputs", {gen_enable, busy, line_len_err, line_cnt_err, err_timeout}, 0);
        chk("reset frame_cnt", frame_cnt, 0);
        chk("reset drop_cnt", drop_cnt, 0);
        prst = 1'b0;
        cyc();
        do_start(0, 1'b0);
        chk("arm busy", busy, 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("arm stop busy", busy, 0);
        chk("arm stop gen_enable", gen_enable, 0);
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("idle stop ignored", busy, 0);
        do_start(2, 1'b1);
        chk("start beats stop", busy, 1);
        send_line(5, 1'b0, -1);
        send_frame();
        chk("seq frame 1", frame_cnt, 1);
        cyc();
        chk("seq still running", busy, 1);
        start = 1'b1;
        frame_limit = 16'd1;
        cyc();
        start = 1'b0;
        chk("busy start ignored", frame_cnt, 1);
        send_frame();
        chk("seq frame 2", frame_cnt, 2);
        drain_chk("seq");
        chk("pre-sof beats ignored", line_len_err, 0);
        do_start(0, 1'b0);
        send_line(8, 1'b1, -1);
        #2 prst = 1'b1;
        #1;
        chk("async reset gen_enable", gen_enable, 0);
        chk("async reset busy", busy, 0);
        @(negedge pclk);
        prst = 1'b0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_gen_ctrl.md
Name: video_gen_ctrl

Overview:
- Run controller for the test-pattern video source: sync generator, pattern generator and native-to-AXI-stream bridge.
- Drives the source `enable` and starts/stops it on frame boundaries.
- Monitors the AXI-stream output to count frames and check line length, line count and backpressure.
- Sits beside the pattern source in colour-pattern synthesis builds and is controlled by a CPU or sequencer.

Parameters:
- FRAME_W, 16, width of frame_limit and frame_cnt.
- TIMEOUT, 1048576, watchdog cycle count without a handshake (used only with VGC_TIMEOUT_EN).

Ports:
- pclk  in  1  pixel clock; all logic on its rising edge.
- prst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse; begin a run.
- stop  in  1  single-cycle pulse; end the run at the next frame boundary.
- frame_limit  in  FRAME_W  frames to emit; 0 means continuous. Sampled on accepted start.
- hactive  in  16  expected pixels per line, from the sync generator.
- vactive  in  16  expected lines per frame, from the sync generator.
- axis_tvalid  in  1  monitored stream valid.
- axis_tready  in  1  monitored stream ready.
- axis_tuser  in  1  monitored stream start-of-frame flag.
- axis_tlast  in  1  monitored stream end-of-line flag.
- gen_enable  out  1  enable to the pattern source.
- busy  out  1  high in any state except IDLE.
- frame_cnt  out  FRAME_W  complete frames in the current run.
- line_len_err  out  1  sticky: a line length differed from hactive.
- line_cnt_err  out  1  sticky: a frame's line count differed from vactive.
- drop_cnt  out  16  saturating count of cycles with tvalid=1 and tready=0.
- err_timeout  out  1  sticky watchdog flag; tied 0 without VGC_TIMEOUT_EN.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and all counters are 0.
- hs = axis_tvalid & axis_tready.
- sof = hs & axis_tuser.
- eol = hs & axis_tlast.
- FSM states and transitions:
  - IDLE: on start, clear frame_cnt, the error flags and drop_cnt, latch frame_limit, and go to ARM. gen_enable rises on the cycle after start (registered).
  - ARM: wait for the first sof, ignoring any beats before it, then go to RUN. A stop in ARM goes directly to IDLE and drops gen_enable.
  - RUN: track pixels and lines.
    - pix_cnt increments on every hs and clears on eol.
    - On eol, if pix_cnt+1 != hactive, set line_len_err.
    - line_cnt increments on eol.
    - eof = eol with line_cnt+1 == vactive. On eof, frame_cnt increments and line_cnt clears.
    - On a sof while line_cnt != 0 (short frame), set line_cnt_err and restart counting from that sof.
    - A pending stop, or frame_cnt reaching the latched limit (non-zero), goes to DRAIN on eof.
  - DRAIN: gen_enable goes 0 on the cycle after entry, then return to IDLE. Entry from RUN occurs only on eof.
- stop is latched as pending in RUN; a stop in IDLE is ignored.
- Simultaneous start and stop in IDLE: start wins and stop is dropped.
- A start while busy is ignored.
- frame_cnt saturates at all-ones.
- drop_cnt counts in ARM and RUN only and saturates at 0xFFFF.
- Sticky flags and counters hold their values in IDLE until the next accepted start.
- Reset mid-run returns everything to the reset state immediately; gen_enable drops asynchronously.

Optional Feature:
- Macro `VGC_TIMEOUT_EN`, defined:
  - A watchdog counter clears on every hs and increments in ARM and RUN.
  - On reaching TIMEOUT it sets err_timeout and forces IDLE; gen_enable drops the next cycle.
- Undefined: no watchdog logic is built and err_timeout is constant 0.

Test Plan:
- hactive=8, vactive=4, frame_limit=3, tready=1, start → gen_enable=1 one cycle later; frame_cnt steps 1,2,3; gen_enable=0 and busy=0 one cycle after the 3rd eof; no error flags set.
- frame_limit=0, stop pulsed mid-line 2 of frame 5 → frame 5 completes; frame_cnt=5; gen_enable falls the cycle after frame 5's eof.
- Inject a 7-beat line (hactive=8) → line_len_err=1 and remains set through the run; frame_cnt is still counted.
- Inject sof after 3 lines (vactive=4) → line_cnt_err=1; the next full frame is counted normally.
- Hold tready=0 for 10 cycles with tvalid=1 → drop_cnt=10. A new start clears it to 0.
- With `VGC_TIMEOUT_EN` and TIMEOUT=100, hold tvalid=0 after start → err_timeout=1 at cycle 100, FSM returns to IDLE, gen_enable=0.
